switch_index_encoder: RTL and testbench
=======================================

// Module: switch_index_encoder
// PURPOSE
//  Parametrised successor to the one-hot switch index encoder. Synchronises raw switches,
//  debounces the whole vector, then encodes it to a registered binary index.
//  Adds a valid flag, an error flag and a change pulse, and selects strict one-hot or priority mode.
//  Sits between the board switches and the ALU operand/operation select logic.
// PARAMETERS
//  N_SW        8               number of switch inputs (>=2)
//  IDX_W       $clog2(N_SW)    width of Index
//  DEBOUNCE    4               cycles the synced vector must stay unchanged before acceptance (>=1)
//  MODE        0               0 = strict one-hot; 1 = priority encoding, lowest set bit wins
// PORTS
//  Clock     in   1      single clock; all state changes on the rising edge
//  Reset_n   in   1      asynchronous reset, active-low
//  Switches  in   N_SW   raw, asynchronous switch levels
//  Index     out  IDX_W  registered index of the last accepted vector
//  Valid     out  1      1 = the current stable vector encodes to Index
//  Error     out  1      1 = the stable vector is multi-hot (MODE 0 only)
//  Changed   out  1      one-cycle pulse on each edge where Index takes a new value
// BEHAVIOUR
//  - Reset (async assert, sync release) clears: Sync1, Sync2, Cand, Cnt, Index, Valid, Error, Changed.
//    All of these go to 0. No output is ever X.
//  - Sync1 <= Switches and Sync2 <= Sync1 form a 2-flop synchroniser.
//  - Debounce on each edge:
//    - if Sync2 != Cand: Cand <= Sync2 and Cnt <= 0.
//    - else if Cnt < DEBOUNCE-1: Cnt++.
//    - Cnt saturates at DEBOUNCE-1.
//  - Acceptance condition Acc: Sync2 == Cand and Cnt == DEBOUNCE-1. While Acc holds, the
//    outputs are re-evaluated from Cand every edge, with no extra delay stage.
//  - Latency: the input changes before edge 1 and is held. Outputs reflect the new vector after
//    edge DEBOUNCE+3 (edge 7 with DEBOUNCE=4).
//  - Glitch rule: any Sync2 change restarts Cnt. Outputs hold their last values during bouncing.
//  - Encoding when Acc holds:
//    - MODE 0:
//      - exactly one bit k set: Index<=k, Valid<=1, Error<=0.
//      - more than one bit set: Index holds, Valid<=0, Error<=1.
//      - all zero: Index holds, Valid<=0, Error<=0.
//    - MODE 1:
//      - any bit set: Index<=lowest set bit, Valid<=1, Error<=0.
//      - all zero: Index holds, Valid<=0, Error<=0.
//  - Changed: set to 1 for exactly one cycle on the edge where Valid is written 1 and the new
//    Index differs from the old Index. Otherwise Changed is 0.
//    - Accepting the same index again does not pulse, even after an invalid period.
//  - Index is never written from an invalid vector. It keeps the last good selection,
//    which is 0 after reset.
//  - Index width: k < N_SW always fits in IDX_W. Encode with a loop, not a fixed case table.
//  - Reset mid-debounce: state returns to reset immediately. Debounce restarts from Cnt=0
//    after release.
// TESTING  (N_SW=8, DEBOUNCE=4 unless noted)
//  1 Reset then Switches=8'h00 -> Index=0, Valid=0, Error=0, Changed=0 for 20 cycles.
//  2 MODE0: Switches 8'h00->8'h20 before edge 1 -> Index=5, Valid=1, Changed=1 after edge 7
//    only; Changed=0 after edge 8.
//  3 Bounce: 8'h04 toggles against 8'h00 every 2 cycles for 10 cycles, then holds ->
//    outputs unchanged during the bounce; Index=2 exactly DEBOUNCE+3 edges after the last toggle.
//  4 MODE0: Index=5, then Switches=8'h22 -> Error=1, Valid=0, Index stays 5, no Changed;
//    back to 8'h20 -> Valid=1, Error=0, Changed=0.
//  5 MODE1: Switches=8'hA8 -> Index=3, Valid=1, Error=0; then 8'h80 -> Index=7, one-cycle Changed.
//  6 Reset_n low mid-debounce (Cnt=2) -> all outputs 0 immediately, same cycle.
//    After release, acceptance takes the full DEBOUNCE+3 edges again.

Source files
------------

// File: rtl/switch_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : switch_index_encoder
// Brief    : Synchronises raw board switches, debounces the whole vector and
//            encodes it to a registered binary index with valid, error and
//            change-pulse flags. Strict one-hot (MODE 0) or lowest-bit
//            priority (MODE 1) encoding.
// Revision : 1.0 - initial release
// ============================================================================
module switch_index_encoder #(
  parameter int N_SW     = 8,
  parameter int IDX_W    = $clog2(N_SW),
  parameter int DEBOUNCE = 4,
  parameter int MODE     = 0
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic [N_SW-1:0]  Switches,
  output logic [IDX_W-1:0] Index,
  output logic             Valid,
  output logic             Error,
  output logic             Changed
);

  // A DEBOUNCE of 1 still needs a one-bit counter so the vectors stay legal.
  localparam int             CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  // Synchroniser and debounce state
  logic [N_SW-1:0]  sync1_q;
  logic [N_SW-1:0]  sync2_q;
  logic [N_SW-1:0]  cand_q;
  logic [N_SW-1:0]  cand_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Output state
  logic [IDX_W-1:0] index_q;
  logic [IDX_W-1:0] index_d;
  logic             valid_q;
  logic             valid_d;
  logic             error_q;
  logic             error_d;
  logic             changed_q;
  logic             changed_d;

  // Combinational decode of the candidate vector
  logic             acc;
  logic             any_set;
  logic             multi_set;
  logic [IDX_W-1:0] low_idx;

  // Two-flop synchroniser for the asynchronous switch levels.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= Switches;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: any change restarts the count, otherwise it saturates.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce candidate and stability counter registers.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

  // The vector is accepted only once it has been stable for the full window
  // and the synchroniser still agrees with it on this edge.
  assign acc = (sync2_q == cand_q) && (cnt_q == CNT_MAX);

  // Scan the candidate for its lowest set bit and whether more than one is set.
  always_comb begin
    any_set   = 1'b0;
    multi_set = 1'b0;
    low_idx   = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (cand_q[i]) begin
        if (any_set) begin
          multi_set = 1'b1;
        end else begin
          low_idx = IDX_W'(i);
          any_set = 1'b1;
        end
      end
    end
  end

  // Output next state: only an accepted, encodable vector may move Index.
  always_comb begin
    index_d   = index_q;
    valid_d   = valid_q;
    error_d   = error_q;
    changed_d = 1'b0;
    if (acc) begin
      if (!any_set) begin
        valid_d = 1'b0;
        error_d = 1'b0;
      end else if ((MODE == 0) && multi_set) begin
        valid_d = 1'b0;
        error_d = 1'b1;
      end else begin
        index_d   = low_idx;
        valid_d   = 1'b1;
        error_d   = 1'b0;
        changed_d = (low_idx != index_q);
      end
    end
  end

  // Output registers; Index keeps the last good selection across invalid periods.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      index_q   <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      index_q   <= index_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      changed_q <= changed_d;
    end
  end

  assign Index   = index_q;
  assign Valid   = valid_q;
  assign Error   = error_q;
  assign Changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_index_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_switch_index_encoder
// Brief    : Scoreboard bench for switch_index_encoder. Two instances (MODE 0
//            and MODE 1) share the switch stimulus; expected outputs are
//            queued with the edge number they are due on and compared on the
//            falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_switch_index_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;

  logic [2:0] idx0, idx1;
  logic       v0, v1, e0, e1, c0, c1;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int    due;
    int    dut;
    string tag;
    int    idx;
    int    v;
    int    e;
    int    c;
  } exp_t;

  exp_t sb[$];

  switch_index_encoder #(.N_SW(8), .IDX_W(3), .DEBOUNCE(4), .MODE(0)) u_dut0 (
    .Clock(clk), .Reset_n(rst_n), .Switches(sw),
    .Index(idx0), .Valid(v0), .Error(e0), .Changed(c0)
  );

  switch_index_encoder #(.N_SW(8), .IDX_W(3), .DEBOUNCE(4), .MODE(1)) u_dut1 (
    .Clock(clk), .Reset_n(rst_n), .Switches(sw),
    .Index(idx1), .Valid(v1), .Error(e1), .Changed(c1)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push(input int dut, input int due, input string tag,
                      input int idx, input int v, input int e, input int c);
    exp_t x;
    x.due = due; x.dut = dut; x.tag = tag;
    x.idx = idx; x.v = v; x.e = e; x.c = c;
    sb.push_back(x);
  endtask

  task automatic push2(input int due, input string tag,
                       input int i0, input int va0, input int er0, input int ch0,
                       input int i1, input int va1, input int er1, input int ch1);
    push(0, due, tag, i0, va0, er0, ch0);
    push(1, due, tag, i1, va1, er1, ch1);
  endtask

  // Called right after a falling edge: the next rising edge is edge 1.
  task automatic apply(input logic [7:0] v, output int base);
    sw   = v;
    base = cyc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "/d0.idx"}, int'(idx0), 0);
    chk({tag, "/d0.v"},   int'(v0),   0);
    chk({tag, "/d0.e"},   int'(e0),   0);
    chk({tag, "/d0.c"},   int'(c0),   0);
    chk({tag, "/d1.idx"}, int'(idx1), 0);
    chk({tag, "/d1.v"},   int'(v1),   0);
    chk({tag, "/d1.e"},   int'(e1),   0);
    chk({tag, "/d1.c"},   int'(c1),   0);
  endtask

  // Scoreboard: compare every entry that falls due on this edge.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        string t;
        t = $sformatf("%s@%0d/d%0d", sb[i].tag, sb[i].due, sb[i].dut);
        if (sb[i].dut == 0) begin
          chk({t, ".idx"}, int'(idx0), sb[i].idx);
          chk({t, ".v"},   int'(v0),   sb[i].v);
          chk({t, ".e"},   int'(e0),   sb[i].e);
          chk({t, ".c"},   int'(c0),   sb[i].c);
        end else begin
          chk({t, ".idx"}, int'(idx1), sb[i].idx);
          chk({t, ".v"},   int'(v1),   sb[i].v);
          chk({t, ".e"},   int'(e1),   sb[i].e);
          chk({t, ".c"},   int'(c1),   sb[i].c);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int r;

    // Reset with switches low
    rst_n = 1'b0;
    sw    = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // 1: all-zero vector keeps everything at 0 for 20 cycles
    b = cyc;
    for (int k = 1; k <= 20; k++) push2(b + k, "t1_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);

    // 2: single bit 5, accepted on edge 7 only
    apply(8'h20, b);
    push2(b + 6, "t2_pre",  0, 0, 0, 0, 0, 0, 0, 0);
    push2(b + 7, "t2_acc",  5, 1, 0, 1, 5, 1, 0, 1);
    push2(b + 8, "t2_post", 5, 1, 0, 0, 5, 1, 0, 0);
    repeat (10) @(negedge clk);

    // 4: multi-hot 8'h22 -> error in MODE 0, lowest bit 1 in MODE 1
    apply(8'h22, b);
    push2(b + 6, "t4_pre",  5, 1, 0, 0, 5, 1, 0, 0);
    push2(b + 7, "t4_acc",  5, 0, 1, 0, 1, 1, 0, 1);
    push2(b + 8, "t4_post", 5, 0, 1, 0, 1, 1, 0, 0);
    repeat (10) @(negedge clk);

    // 4b: back to 8'h20 -> same index in MODE 0, so no change pulse
    apply(8'h20, b);
    push2(b + 7, "t4_back", 5, 1, 0, 0, 5, 1, 0, 1);
    push2(b + 8, "t4_hold", 5, 1, 0, 0, 5, 1, 0, 0);
    repeat (10) @(negedge clk);

    // Settle to all-zero: Index holds, Valid drops
    apply(8'h00, b);
    push2(b + 7, "zero", 5, 0, 0, 0, 5, 0, 0, 0);
    repeat (10) @(negedge clk);

    // 3: 8'h04 bouncing against 8'h00 every 2 cycles, ending on 8'h04
    push2(cyc + 1, "t3_b", 5, 0, 0, 0, 5, 0, 0, 0);
    for (int k = 2; k <= 14; k++) push2(cyc + k, "t3_bounce", 5, 0, 0, 0, 5, 0, 0, 0);
    for (int t = 0; t < 5; t++) begin
      apply((t % 2 == 0) ? 8'h04 : 8'h00, b);
      repeat (2) @(negedge clk);
    end
    push2(b + 7, "t3_acc",  2, 1, 0, 1, 2, 1, 0, 1);
    push2(b + 8, "t3_post", 2, 1, 0, 0, 2, 1, 0, 0);
    repeat (8) @(negedge clk);

    // 5: 8'hA8 -> MODE 1 picks bit 3, MODE 0 flags multi-hot
    apply(8'hA8, b);
    push2(b + 7, "t5_a8",   2, 0, 1, 0, 3, 1, 0, 1);
    push2(b + 8, "t5_a8p",  2, 0, 1, 0, 3, 1, 0, 0);
    repeat (10) @(negedge clk);
    apply(8'h80, b);
    push2(b + 7, "t5_80",   7, 1, 0, 1, 7, 1, 0, 1);
    push2(b + 8, "t5_80p",  7, 1, 0, 0, 7, 1, 0, 0);
    repeat (10) @(negedge clk);

    // 6: reset asserted with Cnt=2, outputs clear without waiting for an edge
    apply(8'h10, b);
    repeat (5) @(posedge clk);
    #2;
    chk("t6_pre_idx0", int'(idx0), 7);
    chk("t6_pre_v0",   int'(v0),   1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    repeat (3) @(negedge clk);
    chk_zero("t6_held");
    rst_n = 1'b1;
    r = cyc;
    push2(r + 6, "t6_pre",  0, 0, 0, 0, 0, 0, 0, 0);
    push2(r + 7, "t6_acc",  4, 1, 0, 1, 4, 1, 0, 1);
    push2(r + 8, "t6_post", 4, 1, 0, 0, 4, 1, 0, 0);
    repeat (10) @(negedge clk);

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
